spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_sync.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_sync.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM states, mode field layout and
// synchroniser depth.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // mode = {CPOL, CPHA}
    localparam int CPOL_BIT    = 1;
    localparam int CPHA_BIT    = 0;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with rise/fall strobes
// derived from the synchronised value and its one-cycle-delayed copy.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign dout = sync[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled by the system clock: all four SPI modes, one-word
// tx holding register, back-to-back words within a frame, abort detection.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t                 state, state_nxt;
    logic                   sclk_s, sclk_rise, sclk_fall;
    logic                   cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic [1:0]             mode_q;
    logic [CW-1:0]          bit_cnt;
    logic [1:0]             cs_high_cnt;
    logic                   armed;
    logic [DATA_WIDTH-1:0]  tx_sr, rx_sr, rx_next, hold_data, load_word;
    logic                   hold_full, under_pend;
    logic                   start, stop, sclk_edge, lead, trail;
    logic                   sample, shift, last_bit, reload, load_emit;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .din(cs),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) mosi_sync <= '0;
        else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // A frame may only start once cs has been seen high after the reset
    // values have flushed out of the synchroniser.
    assign armed    = (cs_high_cnt == 2'd3);
    assign busy     = (state == ACTIVE);
    assign tx_ready = !hold_full;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        case (state)
            IDLE:    if (armed && cs_fall) begin state_nxt = ACTIVE; start = 1'b1; end
            ACTIVE:  if (cs_rise)          begin state_nxt = IDLE;   stop  = 1'b1; end
            default: state_nxt = IDLE;
        endcase
        sclk_edge = (state == ACTIVE) && !cs_rise && (sclk_rise || sclk_fall);
        lead      = sclk_edge && (sclk_s != mode_q[CPOL_BIT]);
        trail     = sclk_edge && (sclk_s == mode_q[CPOL_BIT]);
        sample    = mode_q[CPHA_BIT] ? trail : lead;
        // CPHA=0 presents bit 0 at load time, so the trailing edge right after
        // a word boundary must not shift.
        shift     = mode_q[CPHA_BIT] ? lead : (trail && (bit_cnt != '0));
        last_bit  = sample && (bit_cnt == LAST_BIT);
        reload    = start || last_bit;
        load_emit = reload && !(start ? mode[CPHA_BIT] : mode_q[CPHA_BIT]);
        load_word = hold_full ? hold_data : '0;
        rx_next   = (MSB_FIRST != 0) ? {rx_sr[DATA_WIDTH-2:0], mosi_s}
                                     : {mosi_s, rx_sr[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q      <= '0;
            bit_cnt     <= '0;
            cs_high_cnt <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            under_pend  <= 1'b0;
            rx_data     <= '0;
            miso        <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            if (!cs_s)       cs_high_cnt <= '0;
            else if (!armed) cs_high_cnt <= cs_high_cnt + 2'd1;

            if (start) begin
                mode_q  <= mode;
                bit_cnt <= '0;
                rx_sr   <= '0;
            end
            if (stop) begin
                frame_abort <= (bit_cnt != '0);
                bit_cnt     <= '0;
                miso        <= 1'b0;
                under_pend  <= 1'b0;
            end
            if (sample) begin
                rx_sr   <= rx_next;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
                // Underrun is reported when the zero word actually begins,
                // so a reload at the end of the final word stays silent.
                if (bit_cnt == '0 && under_pend) begin
                    tx_underrun <= 1'b1;
                    under_pend  <= 1'b0;
                end
            end
            if (shift) begin
                miso  <= out_bit(tx_sr);
                tx_sr <= shift_word(tx_sr);
            end
            if (reload) begin
                under_pend <= !hold_full;
                hold_full  <= 1'b0;
                if (load_emit) begin
                    miso  <= out_bit(load_word);
                    tx_sr <= shift_word(load_word);
                end else begin
                    tx_sr <= load_word;
                end
            end
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: an 8-bit MSB-first instance and a 16-bit
// LSB-first instance share sclk/mosi and have separate chip selects.
module tb_spi_slave_sync;

    localparam int HALF = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, sclk, mosi, cs8, cs16;
    logic [1:0]  mode;
    logic        miso8, tx_valid8, tx_ready8, rx_valid8, tx_underrun8, frame_abort8, busy8;
    logic [7:0]  tx_data8, rx_data8;
    logic        miso16, tx_valid16, tx_ready16, rx_valid16, tx_underrun16, frame_abort16, busy16;
    logic [15:0] tx_data16, rx_data16;

    int tests = 0;
    int fails = 0;
    int rxv8_cnt = 0, und8_cnt = 0, abt8_cnt = 0, rxv16_cnt = 0;
    logic [7:0]  rx_exp8[$];
    logic [15:0] rx_exp16[$];
    logic [7:0]  e8, last_rx8;
    logic [15:0] e16;

    spi_slave_sync #(.DATA_WIDTH(8), .MSB_FIRST(1)) dut8 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs8), .mosi(mosi), .miso(miso8),
        .mode(mode), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_underrun(tx_underrun8),
        .frame_abort(frame_abort8), .busy(busy8)
    );

    spi_slave_sync #(.DATA_WIDTH(16), .MSB_FIRST(0)) dut16 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs16), .mosi(mosi), .miso(miso16),
        .mode(mode), .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_underrun(tx_underrun16),
        .frame_abort(frame_abort16), .busy(busy16)
    );

    // Scoreboard: expected rx words are queued by the tests, popped here.
    always @(negedge clk) begin
        if (tx_underrun8 === 1'b1) und8_cnt++;
        if (frame_abort8 === 1'b1) abt8_cnt++;
        if (rx_valid8 === 1'b1) begin
            rxv8_cnt++;
            tests++;
            if (rx_exp8.size() == 0) begin
                fails++;
                $display("FAIL rx8_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data8);
            end else begin
                e8 = rx_exp8.pop_front();
                if (rx_data8 !== e8) begin
                    fails++;
                    $display("FAIL rx8_data: got %h, required %h", rx_data8, e8);
                end
            end
        end
        if (rx_valid16 === 1'b1) begin
            rxv16_cnt++;
            tests++;
            if (rx_exp16.size() == 0) begin
                fails++;
                $display("FAIL rx16_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data16);
            end else begin
                e16 = rx_exp16.pop_front();
                if (rx_data16 !== e16) begin
                    fails++;
                    $display("FAIL rx16_data: got %h, required %h", rx_data16, e16);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit i of the result is the i-th bit on the wire.
    function automatic logic [63:0] mk_stream(input logic [31:0] w0, input logic [31:0] w1,
                                              input int width, input bit msb);
        logic [63:0] s = '0;
        for (int i = 0; i < width; i++) begin
            s[i]         = msb ? w0[width-1-i] : w0[i];
            s[width + i] = msb ? w1[width-1-i] : w1[i];
        end
        return s;
    endfunction

    function automatic logic [31:0] get_word(input logic [63:0] s, input int idx,
                                             input int width, input bit msb);
        logic [31:0] w = '0;
        for (int i = 0; i < width; i++) begin
            if (msb) w[width-1-i] = s[idx*width + i];
            else     w[i]         = s[idx*width + i];
        end
        return w;
    endfunction

    task automatic load_tx(input bit sel, input logic [15:0] w, input string name);
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if ((sel ? tx_ready16 : tx_ready8) === 1'b1) begin
                if (sel) begin tx_data16 = w;      tx_valid16 = 1'b1; end
                else     begin tx_data8  = w[7:0]; tx_valid8  = 1'b1; end
                @(negedge clk);
                tx_valid8  = 1'b0;
                tx_valid16 = 1'b0;
                done = 1'b1;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_tx_load: tx_ready stayed 0 for 200 cycles, required 1", name);
        end
    endtask

    task automatic master_frame(input bit sel, input logic [1:0] m, input logic [63:0] stream,
                                input int nbits, output logic [63:0] got);
        got  = '0;
        mode = m;
        sclk = m[1];
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        if (sel) cs16 = 1'b0; else cs8 = 1'b0;
        repeat (6) @(negedge clk);
        mode = ~m;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                mosi = stream[i];
                repeat (HALF) @(negedge clk);
                got[i] = sel ? miso16 : miso8;
                sclk = ~m[1];
                repeat (HALF) @(negedge clk);
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = stream[i];
                repeat (HALF) @(negedge clk);
                got[i] = sel ? miso16 : miso8;
                sclk = m[1];
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        cs8  = 1'b1;
        cs16 = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cs8 = 1'b1; cs16 = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00;
        tx_valid8 = 1'b0; tx_valid16 = 1'b0; tx_data8 = '0; tx_data16 = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_ready8, busy8, miso8, rx_valid8, tx_underrun8, frame_abort8} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags8: got %b, required 100000",
                     {tx_ready8, busy8, miso8, rx_valid8, tx_underrun8, frame_abort8});
        end
        tests++;
        if (rx_data8 !== 8'h00) begin
            fails++; $display("FAIL reset_rx8: got %h, required 00", rx_data8);
        end
        tests++;
        if ({tx_ready16, busy16, miso16, rx_valid16, rx_data16} !== {4'b1000, 16'h0}) begin
            fails++;
            $display("FAIL reset_16: got %b/%h, required 1000/0000",
                     {tx_ready16, busy16, miso16, rx_valid16}, rx_data16);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if ({tx_ready8, busy8, miso8} !== 3'b100) begin
            fails++; $display("FAIL post_reset8: got %b, required 100", {tx_ready8, busy8, miso8});
        end
    endtask

    task automatic test_mode0_basic();
        logic [63:0] got;
        int r0 = rxv8_cnt, u0 = und8_cnt;
        load_tx(1'b0, 16'h00A5, "basic");
        rx_exp8.push_back(8'h3C);
        master_frame(1'b0, 2'b00, mk_stream(32'h3C, 32'h0, 8, 1'b1), 8, got);
        tests++;
        if (got[7:0] !== 8'hA5) begin
            fails++; $display("FAIL basic_miso_bits: got %b (first bit at right), required 10100101", got[7:0]);
        end
        tests++;
        if (rxv8_cnt - r0 != 1) begin
            fails++; $display("FAIL basic_rx_valid_count: got %0d, required 1", rxv8_cnt - r0);
        end
        tests++;
        if (rx_data8 !== 8'h3C || und8_cnt != u0) begin
            fails++; $display("FAIL basic_rx_hold: rx_data %h underruns %0d, required 3c 0", rx_data8, und8_cnt - u0);
        end
        last_rx8 = 8'h3C;
    endtask

    task automatic test_all_modes();
        logic [63:0] got;
        for (int m = 0; m < 4; m++) begin
            int r0 = rxv8_cnt, u0 = und8_cnt;
            load_tx(1'b0, 16'h0012, "modes_w0");
            rx_exp8.push_back(8'h81);
            rx_exp8.push_back(8'h7E);
            fork
                master_frame(1'b0, 2'(m), mk_stream(32'h81, 32'h7E, 8, 1'b1), 16, got);
                load_tx(1'b0, 16'h0034, "modes_w1");
            join
            tests++;
            if (get_word(got, 0, 8, 1'b1) !== 32'h12 || get_word(got, 1, 8, 1'b1) !== 32'h34) begin
                fails++;
                $display("FAIL mode%0d_master_rx: got %h %h, required 12 34", m,
                         get_word(got, 0, 8, 1'b1), get_word(got, 1, 8, 1'b1));
            end
            tests++;
            if (rxv8_cnt - r0 != 2 || und8_cnt != u0 || rx_exp8.size() != 0) begin
                fails++;
                $display("FAIL mode%0d_pulses: rx_valid %0d underrun %0d pending %0d, required 2 0 0",
                         m, rxv8_cnt - r0, und8_cnt - u0, rx_exp8.size());
            end
        end
        last_rx8 = 8'h7E;
    endtask

    task automatic test_underrun();
        logic [63:0] got;
        int r0 = rxv8_cnt, u0 = und8_cnt;
        tests++;
        if (tx_ready8 !== 1'b1) begin
            fails++; $display("FAIL underrun_ready: got %b, required 1", tx_ready8);
        end
        rx_exp8.push_back(8'h5A);
        master_frame(1'b0, 2'b00, mk_stream(32'h5A, 32'h0, 8, 1'b1), 8, got);
        tests++;
        if (got[7:0] !== 8'h00) begin
            fails++; $display("FAIL underrun_miso: got %b, required 00000000", got[7:0]);
        end
        tests++;
        if (und8_cnt - u0 != 1 || rxv8_cnt - r0 != 1 || rx_data8 !== 8'h5A) begin
            fails++;
            $display("FAIL underrun_pulses: underrun %0d rx_valid %0d rx %h, required 1 1 5a",
                     und8_cnt - u0, rxv8_cnt - r0, rx_data8);
        end
        last_rx8 = 8'h5A;
    endtask

    task automatic test_abort();
        logic [63:0] got;
        int r0 = rxv8_cnt, a0 = abt8_cnt;
        load_tx(1'b0, 16'h00FF, "abort_w0");
        master_frame(1'b0, 2'b00, mk_stream(32'h55, 32'h0, 8, 1'b1), 5, got);
        tests++;
        if (abt8_cnt - a0 != 1 || rxv8_cnt != r0) begin
            fails++;
            $display("FAIL abort_pulses: frame_abort %0d rx_valid %0d, required 1 0", abt8_cnt - a0, rxv8_cnt - r0);
        end
        tests++;
        if (rx_data8 !== last_rx8) begin
            fails++; $display("FAIL abort_rx_kept: got %h, required %h", rx_data8, last_rx8);
        end
        load_tx(1'b0, 16'h0096, "abort_w1");
        rx_exp8.push_back(8'hC3);
        master_frame(1'b0, 2'b00, mk_stream(32'hC3, 32'h0, 8, 1'b1), 8, got);
        tests++;
        if (get_word(got, 0, 8, 1'b1) !== 32'h96 || rx_data8 !== 8'hC3 || abt8_cnt - a0 != 1) begin
            fails++;
            $display("FAIL abort_recover: master %h rx %h aborts %0d, required 96 c3 1",
                     get_word(got, 0, 8, 1'b1), rx_data8, abt8_cnt - a0);
        end
        last_rx8 = 8'hC3;
    endtask

    task automatic test_lsb16();
        logic [63:0] got;
        int r0 = rxv16_cnt;
        load_tx(1'b1, 16'h1234, "lsb16");
        rx_exp16.push_back(16'hBEEF);
        master_frame(1'b1, 2'b00, mk_stream(32'hBEEF, 32'h0, 16, 1'b0), 16, got);
        tests++;
        if (get_word(got, 0, 16, 1'b0) !== 32'h1234) begin
            fails++; $display("FAIL lsb16_master_rx: got %h, required 1234", get_word(got, 0, 16, 1'b0));
        end
        tests++;
        if (rx_data16 !== 16'hBEEF || rxv16_cnt - r0 != 1 || rx_exp16.size() != 0) begin
            fails++;
            $display("FAIL lsb16_rx: rx %h pulses %0d, required beef 1", rx_data16, rxv16_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] got;
        int r0 = rxv8_cnt, u0 = und8_cnt, a0 = abt8_cnt;
        load_tx(1'b0, 16'h0099, "rstmid_w0");
        fork
            master_frame(1'b0, 2'b00, mk_stream(32'hE7, 32'h0, 8, 1'b1), 8, got);
            begin
                repeat (48) @(negedge clk);
                tests++;
                if (busy8 !== 1'b1) begin
                    fails++; $display("FAIL rstmid_busy_before: got %b, required 1", busy8);
                end
                reset_n = 1'b0;
                @(negedge clk);
                tests++;
                if ({tx_ready8, busy8, miso8, rx_valid8, tx_underrun8, frame_abort8} !== 6'b100000
                    || rx_data8 !== 8'h00) begin
                    fails++;
                    $display("FAIL rstmid_outputs: got %b rx %h, required 100000 00",
                             {tx_ready8, busy8, miso8, rx_valid8, tx_underrun8, frame_abort8}, rx_data8);
                end
                reset_n = 1'b1;
            end
        join
        tests++;
        if (rxv8_cnt != r0 || und8_cnt != u0 || abt8_cnt != a0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_no_pulses: rx_valid %0d underrun %0d abort %0d busy %b, required 0 0 0 0",
                     rxv8_cnt - r0, und8_cnt - u0, abt8_cnt - a0, busy8);
        end
        load_tx(1'b0, 16'h0066, "rstmid_w1");
        rx_exp8.push_back(8'hA7);
        master_frame(1'b0, 2'b00, mk_stream(32'hA7, 32'h0, 8, 1'b1), 8, got);
        tests++;
        if (get_word(got, 0, 8, 1'b1) !== 32'h66 || rx_data8 !== 8'hA7 || rxv8_cnt - r0 != 1) begin
            fails++;
            $display("FAIL rstmid_next_frame: master %h rx %h pulses %0d, required 66 a7 1",
                     get_word(got, 0, 8, 1'b1), rx_data8, rxv8_cnt - r0);
        end
    endtask

    initial begin
        last_rx8 = 8'h00;
        test_reset();
        test_mode0_basic();
        test_all_modes();
        test_underrun();
        test_abort();
        test_lsb16();
        test_reset_mid_frame();
        tests++;
        if (rx_exp8.size() != 0 || rx_exp16.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d/%0d words never received, required 0/0",
                     rx_exp8.size(), rx_exp16.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
